mem_module_dp: RTL and testbench
================================

Name: mem_module_dp

Overview:
- Dual-port, picorv32-native-bus on-chip RAM. Next generation of the single-port core memory.
- Two independent requester ports share one word array: port 0 is normally instruction fetch, port 1 is normally data/DMA.
- Adds parametrised depth and base address, selectable read latency, round-robin arbitration, and arbitrary byte-strobe writes.
- Out-of-range accesses are handled with an error pulse and a default read value instead of aliasing.

Parameters:
- INIT_FILE, "", hex image loaded with $readmemh at elaboration; no load when empty.
- DEPTH_WORDS, 8192, number of 32-bit words; any value ≥ 2; need not be a power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- READ_LATENCY, 1, cycles from grant to ready; legal values 1 or 2. 2 adds an output register stage.
- OOR_RDATA, 32'hDEAD_BEEF, read data returned for out-of-range reads.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- p0_mem_valid  in  1  port 0 request, held until p0_mem_ready
- p0_mem_instr  in  1  informational only; no functional effect
- p0_mem_ready  out  1  one-cycle completion pulse
- p0_mem_addr  in  32  byte address
- p0_mem_wdata  in  32  write data
- p0_mem_wstrb  in  4  byte enables; 0 = read
- p0_mem_rdata  out  32  read data, valid while p0_mem_ready=1
- p0_err  out  1  pulses with p0_mem_ready when the access was out of range
- p1_mem_valid, p1_mem_instr, p1_mem_ready, p1_mem_addr, p1_mem_wdata, p1_mem_wstrb, p1_mem_rdata, p1_err  same as port 0

Behaviour:
- Reset values: all *_mem_ready=0, *_err=0, *_mem_rdata=0, FSM=IDLE, round-robin pointer favours port 0. Array contents are not cleared.
- Reset mid-operation: all outputs return to reset values on the next edge and the in-flight access is dropped. A write already committed to the array stays committed.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if any valid, grant one port and latch its addr/wdata/wstrb.
    - Only one valid: that port wins.
    - Both valid: the port not granted last wins.
    - With READ_LATENCY=1, go to RESP; with READ_LATENCY=2, go to WAIT.
  - WAIT: one cycle, then RESP.
  - RESP: assert the granted port's ready (and err if out of range) for exactly one cycle, drive its rdata, return to IDLE.
- Latency: valid sampled in IDLE at cycle 0 → ready high in cycle READ_LATENCY. The earliest next grant is cycle READ_LATENCY+1.
  - Sustained throughput is one access per READ_LATENCY+1 cycles.
  - If a requester keeps valid high after ready, that is treated as a new request.
- Fairness: the last-granted pointer updates on every grant. With both ports continuously valid, grants strictly alternate.
- Address decode:
  - word index = (addr − BASE_ADDR) >> 2; addr[1:0] is ignored.
  - Out of range when addr < BASE_ADDR or index ≥ DEPTH_WORDS. Use 33-bit arithmetic so no wrap-around occurs.
- Writes (wstrb≠0): for every set strobe bit i, byte i of the word is replaced by wdata byte i. All 15 non-zero patterns are legal, including 4'h5 and 4'hB. The write commits on the grant edge.
- Reads (wstrb=0): array read on the grant edge; returned data reflects all earlier committed writes.
- A read granted the cycle after a write to the same word returns the new data.
- Out of range: no array write. Read returns OOR_RDATA, write returns rdata=0. Ready still pulses, err pulses with it.
- The non-granted port's ready and err stay 0; its rdata holds its last value.
- A port whose valid drops before grant is silently abandoned. No error is raised and the round-robin pointer is unchanged.

Test Plan:
- Single read, READ_LATENCY=1, INIT word[3]=32'h1234_5678: p0 reads addr 0x0C → p0_mem_ready in cycle 1, rdata=0x12345678, p0_err=0.
- Byte-strobe merge: word[5]=0xAABBCCDD; p1 writes 0x11223344 with wstrb=4'h5 to addr 0x14, then p0 reads 0x14 → 0xAA22CC44.
- Contention: p0 and p1 both valid in the same cycle from reset, held, READ_LATENCY=2 → grant order p0,p1,p0,p1; each ready 3 cycles apart; no ready overlap.
- Out of range: BASE_ADDR=0x1000, DEPTH_WORDS=16.
  - Read at 0x1040 → ready, err=1, rdata=0xDEADBEEF.
  - Write at 0x0FFC → ready, err=1; a subsequent read of 0x1000 returns the unchanged value.
- Reset mid-op: READ_LATENCY=2, assert rst in the WAIT cycle → no ready pulse. The next request after rst deasserts completes normally with p0 priority.
- Back-to-back write then read of the same word: read returns the written data with latency READ_LATENCY.

Source files
------------

// File: rtl/mem_module_dp.sv
// Dual-port on-chip RAM on the picorv32 native bus; two requesters share one word array via round-robin.
// Latency: valid sampled in IDLE -> ready pulse READ_LATENCY (1 or 2) cycles later; one access per READ_LATENCY+1 cycles.
// Backpressure: requesters hold valid until their ready pulse; the losing port simply waits, a dropped valid is abandoned.
//
// Ports: clk, rst (sync, active-high); per port pN_: mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb in,
//        mem_ready (one-cycle completion), mem_rdata (held between completions), err (out-of-range flag with ready) out.
module mem_module_dp #(
    parameter string       INIT_FILE    = "",
    parameter int          DEPTH_WORDS  = 8192,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] OOR_RDATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_mem_valid,
    input  logic        p0_mem_instr,
    output logic        p0_mem_ready,
    input  logic [31:0] p0_mem_addr,
    input  logic [31:0] p0_mem_wdata,
    input  logic [3:0]  p0_mem_wstrb,
    output logic [31:0] p0_mem_rdata,
    output logic        p0_err,
    input  logic        p1_mem_valid,
    input  logic        p1_mem_instr,
    output logic        p1_mem_ready,
    input  logic [31:0] p1_mem_addr,
    input  logic [31:0] p1_mem_wdata,
    input  logic [3:0]  p1_mem_wstrb,
    output logic [31:0] p1_mem_rdata,
    output logic        p1_err
);
    localparam int AW = (DEPTH_WORDS > 2) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state, state_nxt;
    logic        last_gnt;      // 1: port 1 was granted most recently
    logic        gnt_port;      // port owning the access in flight
    logic        oor_q;
    logic [31:0] rd_q;          // data captured on the grant edge
    logic [31:0] rd_q2;         // extra output stage used when READ_LATENCY == 2
    logic [31:0] resp_data;
    logic [31:0] hold0, hold1;  // last completed rdata per port

    // Grant selection: a lone requester wins; on a tie the port not granted last wins.
    logic        grant;
    logic        sel;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_wstrb;
    logic [32:0] off;
    logic [29:0] widx;
    logic        a_oor, a_wr;
    logic [AW-1:0] idx;

    always_comb begin
        grant   = (state == IDLE) && (p0_mem_valid || p1_mem_valid);
        sel     = p1_mem_valid && (!p0_mem_valid || !last_gnt);
        a_addr  = sel ? p1_mem_addr  : p0_mem_addr;
        a_wdata = sel ? p1_mem_wdata : p0_mem_wdata;
        a_wstrb = sel ? p1_mem_wstrb : p0_mem_wstrb;
        // 33-bit subtraction: a borrow into bit 32 means the address is below the base.
        off     = {1'b0, a_addr} - {1'b0, BASE_ADDR};
        widx    = off[31:2];
        a_oor   = off[32] || ({2'b00, widx} >= 32'(DEPTH_WORDS));
        a_wr    = |a_wstrb;
        idx     = widx[AW-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant) state_nxt = (READ_LATENCY == 2) ? WAIT : RESP;
            WAIT: state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Array access happens on the grant edge, so a later grant always sees earlier writes.
    always_ff @(posedge clk) begin
        if (grant && !rst && !a_oor && a_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (a_wstrb[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            gnt_port <= 1'b0;
            oor_q    <= 1'b0;
            rd_q     <= '0;
            rd_q2    <= '0;
            hold0    <= '0;
            hold1    <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                last_gnt <= sel;
                gnt_port <= sel;
                oor_q    <= a_oor;
                if (a_wr)       rd_q <= '0;
                else if (a_oor) rd_q <= OOR_RDATA;
                else            rd_q <= mem[idx];
            end
            if (state == WAIT) rd_q2 <= rd_q;
            if (state == RESP && !gnt_port) hold0 <= resp_data;
            if (state == RESP &&  gnt_port) hold1 <= resp_data;
        end
    end

    always_comb begin
        resp_data    = (READ_LATENCY == 2) ? rd_q2 : rd_q;
        p0_mem_ready = (state == RESP) && !gnt_port;
        p1_mem_ready = (state == RESP) &&  gnt_port;
        p0_err       = p0_mem_ready && oor_q;
        p1_err       = p1_mem_ready && oor_q;
        p0_mem_rdata = p0_mem_ready ? resp_data : hold0;
        p1_mem_rdata = p1_mem_ready ? resp_data : hold1;
    end

    // instr flags are informational; low address bits and high index bits are not needed.
    logic unused_bits;
    assign unused_bits = ^{p0_mem_instr, p1_mem_instr, off[1:0], widx};

endmodule

// File: tb/tb_mem_module_dp.sv
module tb_mem_module_dp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst2;
    logic        vld[4], instr[4], rdy[4], err[4];
    logic [31:0] addr[4], wdata[4], rdata[4];
    logic [3:0]  wstrb[4];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ntot = 0;
    int npass = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[4][$];

    // dut1: latency 1, base 0, 20 words (not a power of two)
    mem_module_dp #(.DEPTH_WORDS(20), .BASE_ADDR(32'h0), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1),
        .p0_mem_valid(vld[0]), .p0_mem_instr(instr[0]), .p0_mem_ready(rdy[0]),
        .p0_mem_addr(addr[0]), .p0_mem_wdata(wdata[0]), .p0_mem_wstrb(wstrb[0]),
        .p0_mem_rdata(rdata[0]), .p0_err(err[0]),
        .p1_mem_valid(vld[1]), .p1_mem_instr(instr[1]), .p1_mem_ready(rdy[1]),
        .p1_mem_addr(addr[1]), .p1_mem_wdata(wdata[1]), .p1_mem_wstrb(wstrb[1]),
        .p1_mem_rdata(rdata[1]), .p1_err(err[1])
    );

    // dut2: latency 2, base 0x1000, 16 words
    mem_module_dp #(.DEPTH_WORDS(16), .BASE_ADDR(32'h1000), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst2),
        .p0_mem_valid(vld[2]), .p0_mem_instr(instr[2]), .p0_mem_ready(rdy[2]),
        .p0_mem_addr(addr[2]), .p0_mem_wdata(wdata[2]), .p0_mem_wstrb(wstrb[2]),
        .p0_mem_rdata(rdata[2]), .p0_err(err[2]),
        .p1_mem_valid(vld[3]), .p1_mem_instr(instr[3]), .p1_mem_ready(rdy[3]),
        .p1_mem_addr(addr[3]), .p1_mem_wdata(wdata[3]), .p1_mem_wstrb(wstrb[3]),
        .p1_mem_rdata(rdata[3]), .p1_err(err[3])
    );

    // Monitor: pops the expected response whenever a port completes.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rdy[k]) begin
                ntot++;
                if (q[k].size() == 0) begin
                    $display("FAIL unexpected_ready port=%0d cyc=%0d rdata=%h err=%b (no request outstanding)",
                             k, cyc, rdata[k], err[k]);
                end else begin
                    exp_t e;
                    e = q[k].pop_front();
                    if (rdata[k] === e.rdata && err[k] === e.err && cyc == e.cyc && rdy[k ^ 1] === 1'b0)
                        npass++;
                    else
                        $display("FAIL resp port=%0d got rdata=%h err=%b cyc=%0d other_rdy=%b want rdata=%h err=%b cyc=%0d other_rdy=0",
                                 k, rdata[k], err[k], cyc, rdy[k ^ 1], e.rdata, e.err, e.cyc);
                end
            end else if (err[k] !== 1'b0) begin
                ntot++;
                $display("FAIL err_without_ready port=%0d cyc=%0d err=%b want 0", k, cyc, err[k]);
            end
        end
    end

    // Issue one request and hold valid until ready; lat is the expected ready cycle relative to issue.
    task automatic req(input int k, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input logic [31:0] er, input logic ee, input int lat);
        exp_t e;
        int   n;
        e.rdata = er;
        e.err   = ee;
        e.cyc   = cyc + lat;
        q[k].push_back(e);
        addr[k]  = a;
        wdata[k] = wd;
        wstrb[k] = ws;
        vld[k]   = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (rdy[k]) break;
            n++;
            if (n > 40) begin
                ntot++;
                $display("FAIL timeout port=%0d addr=%h got no ready want ready within 40 cycles", k, a);
                break;
            end
        end
        @(posedge clk);
        #1;
        vld[k]   = 1'b0;
        wstrb[k] = 4'h0;
    endtask

    task automatic check_idle(input int k, input string name);
        ntot++;
        if (rdy[k] === 1'b0 && err[k] === 1'b0 && rdata[k] === 32'h0)
            npass++;
        else
            $display("FAIL %s port=%0d got rdy=%b err=%b rdata=%h want 0/0/00000000", name, k, rdy[k], err[k], rdata[k]);
    endtask

    task automatic check_hold(input int k, input logic [31:0] want);
        ntot++;
        if (rdata[k] === want && rdy[k] === 1'b0)
            npass++;
        else
            $display("FAIL rdata_hold port=%0d got rdata=%h rdy=%b want rdata=%h rdy=0", k, rdata[k], rdy[k], want);
    endtask

    initial begin
        rst1 = 1'b1;
        rst2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vld[k] = 1'b0; instr[k] = (k % 2 == 0); addr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) check_idle(k, "reset_state");
        rst1 = 1'b0;
        rst2 = 1'b0;
        @(posedge clk);
        #1;

        // ---- dut1, latency 1 ----
        req(0, 32'h0C, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1);
        req(0, 32'h0C, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1);   // write then read same word
        req(0, 32'h0F, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1);   // addr[1:0] ignored
        req(1, 32'h14, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0, 1);
        req(1, 32'h14, 32'h1122_3344, 4'h5, 32'h0, 1'b0, 1);
        req(0, 32'h14, 32'h0, 4'h0, 32'hAA22_CC44, 1'b0, 1);
        req(1, 32'h14, 32'h5566_7788, 4'hB, 32'h0, 1'b0, 1);
        req(1, 32'h14, 32'h0, 4'h0, 32'h5522_7788, 1'b0, 1);
        req(1, 32'h4C, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 1);   // last in-range word
        req(0, 32'h4C, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1);
        req(0, 32'h50, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 1);   // index == depth
        req(1, 32'h50, 32'h1, 4'hF, 32'h0, 1'b1, 1);
        req(1, 32'h4C, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1);

        // ---- dut2, latency 2, base 0x1000 ----
        req(2, 32'h1000, 32'hCAFE_0001, 4'hF, 32'h0, 1'b0, 2);
        req(3, 32'h1004, 32'hCAFE_0002, 4'hF, 32'h0, 1'b0, 2);
        req(2, 32'h1008, 32'hCAFE_0003, 4'hF, 32'h0, 1'b0, 2);
        req(3, 32'h100C, 32'hCAFE_0004, 4'hF, 32'h0, 1'b0, 2);
        rst2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst2 = 1'b0;
        // contention from reset: p0, p1, p0, p1, three cycles apart
        fork
            begin
                req(2, 32'h1000, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, 2);
                req(2, 32'h1008, 32'h0, 4'h0, 32'hCAFE_0003, 1'b0, 5);
            end
            begin
                req(3, 32'h1004, 32'h0, 4'h0, 32'hCAFE_0002, 1'b0, 5);
                req(3, 32'h100C, 32'h0, 4'h0, 32'hCAFE_0004, 1'b0, 5);
            end
        join
        check_hold(2, 32'hCAFE_0003);
        check_hold(3, 32'hCAFE_0004);

        req(2, 32'h1040, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 2);
        req(3, 32'h0FFC, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 2);
        req(2, 32'h1000, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, 2);
        req(3, 32'h103C, 32'h7777_8888, 4'hF, 32'h0, 1'b0, 2);
        req(2, 32'h103C, 32'h0, 4'h0, 32'h7777_8888, 1'b0, 2);

        // reset asserted during the WAIT cycle: the access must vanish
        addr[2]  = 32'h1004;
        wstrb[2] = 4'h0;
        vld[2]   = 1'b1;
        @(posedge clk);
        #1;
        rst2   = 1'b1;
        vld[2] = 1'b0;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        check_idle(2, "reset_midop");
        repeat (3) @(posedge clk);
        #1;
        check_idle(2, "after_reset_midop");
        fork
            req(2, 32'h1000, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, 2);
            req(3, 32'h1004, 32'h0, 4'h0, 32'hCAFE_0002, 1'b0, 5);
        join

        repeat (3) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            ntot++;
            if (q[k].size() == 0) npass++;
            else $display("FAIL outstanding port=%0d got %0d pending responses want 0", k, q[k].size());
        end
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
